// File: rtl/serial_sub.sv
// Bit-serial subtractor: one full_sub cell is stepped LSB-first over WIDTH clocks
// to form (a - b - bin) mod 2^WIDTH and the final borrow.

module full_sub (
  input  logic a,
  input  logic b,
  input  logic b_in,
  output logic difference,
  output logic b_out
);

  logic a_xor_b;

  assign a_xor_b    = a ^ b;
  assign difference = a_xor_b ^ b_in;
  // Borrow when the minuend bit is short, or equal bits pass the incoming borrow on.
  assign b_out      = (~a & b) | (~a_xor_b & b_in);

endmodule

module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] difference,
  output logic             bout,
  output logic [0:0]       dbg_state
);

  // Handshake: start is a request taken on any rising edge where busy=0; a, b and
  // bin are captured on that same edge. done pulses for one cycle with difference
  // and bout valid, and those outputs hold until the next completion or reset.

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] diff_sr;
  logic             brw;
  logic [CNT_W-1:0] cnt;

  logic             fs_diff;
  logic             fs_bout;
  logic [WIDTH-1:0] diff_next;

  full_sub u_cell (
    .a          (a_sr[0]),
    .b          (b_sr[0]),
    .b_in       (brw),
    .difference (fs_diff),
    .b_out      (fs_bout)
  );

  // Only the upper WIDTH-1 result bits need storage; the newest bit comes from the cell.
  assign diff_next = {fs_diff, diff_sr};
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_sr       <= '0;
      b_sr       <= '0;
      diff_sr    <= '0;
      brw        <= 1'b0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      difference <= '0;
      bout       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            brw   <= bin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          diff_sr <= diff_next[WIDTH-1:1];
          brw     <= fs_bout;
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          if (cnt == LAST) begin
            difference <= diff_next;
            bout       <= fs_bout;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A result can only be reported once the datapath has gone idle.
  assert property (@(posedge clk) disable iff (!rst_n) done |-> !busy);
  assert property (@(posedge clk) disable iff (!rst_n) busy == (state == RUN));

endmodule
